keccak_in_buffer: RTL and testbench

Input buffer placed directly upstream of the Keccak permutation core. It accepts the message one 64-bit lane per cycle over a valid/ready stream and assembles the lanes into one rate block of RATE_LANES lanes. It then presents the whole block to the core with a block-level valid/ready handshake and flags the final block of each message. This stage is single-buffered: filling and draining never overlap.

---
 rtl/keccak_in_buffer_pkg.sv | 16 +
 rtl/keccak_in_buffer_pad_lane.sv | 27 ++
 rtl/keccak_in_buffer.sv | 129 ++++++++++++
 tb/tb_keccak_in_buffer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/keccak_in_buffer_pkg.sv
// pkg_keccak: lane/block types, rate constant and input-buffer FSM states. Rev 1.0
`default_nettype none
package pkg_keccak;
  localparam int N          = 64;
  localparam int RATE_LANES = 17;

  typedef logic [N-1:0]             k_lane;
  typedef k_lane [RATE_LANES-1:0]   k_block;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_FULL   = 2'd1,
    ST_PADBLK = 2'd2
  } k_buf_state_e;
endpackage
`default_nettype wire

// File: rtl/keccak_in_buffer_pad_lane.sv
// keccak_pad_lane: pad10*1 OR mask for one lane (used only with KECCAK_PAD_EN). Rev 1.0
`default_nettype none
module keccak_pad_lane #(
  parameter int RATE_LANES = pkg_keccak::RATE_LANES,
  parameter int N          = pkg_keccak::N
) (
  input  logic [4:0]   i_lane_idx,
  input  logic [4:0]   i_last_idx,
  input  logic         i_pad_active,
  input  logic         i_pad_blk,
  output logic [N-1:0] o_mask
);
  localparam logic [4:0] c_last_lane = 5'(RATE_LANES - 1);

  always_comb begin
    o_mask = '0;
    if (i_pad_blk) begin
      if (i_lane_idx == 5'd0)        o_mask[0]   = 1'b1;
      if (i_lane_idx == c_last_lane) o_mask[N-1] = 1'b1;
    end else if (i_pad_active && (i_last_idx < c_last_lane)) begin
      // Both bits land in the final lane when the message ends one lane short.
      if (i_lane_idx == i_last_idx + 5'd1) o_mask[0]   = 1'b1;
      if (i_lane_idx == c_last_lane)       o_mask[N-1] = 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/keccak_in_buffer.sv
// keccak_in_buffer: lane-to-rate-block assembler ahead of the Keccak core. Rev 1.0
// Optional lane-granular pad10*1 insertion with macro KECCAK_PAD_EN.
`default_nettype none
module keccak_in_buffer #(
  parameter int RATE_LANES = pkg_keccak::RATE_LANES,
  parameter int N          = pkg_keccak::N
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          din,
  input  logic                  din_valid,
  input  logic                  din_last,
  output logic                  din_ready,
  output logic [RATE_LANES*N-1:0] blk_data,
  output logic                  blk_valid,
  output logic                  blk_last,
  input  logic                  blk_ready
);
  import pkg_keccak::*;

  localparam logic [4:0] c_last_lane = 5'(RATE_LANES - 1);
`ifdef KECCAK_PAD_EN
  localparam bit c_pad_en = 1'b1;
`else
  localparam bit c_pad_en = 1'b0;
`endif

  k_buf_state_e r_state;
  logic [N-1:0] r_buf [RATE_LANES];
  logic [N-1:0] w_mask [RATE_LANES];
  logic [4:0]   r_cnt;
  logic         r_din_ready;
  logic         r_blk_valid;
  logic         r_blk_last;
  logic         r_pad_pending;
  logic         w_accept;
  logic         w_close;

  assign w_accept  = din_valid & r_din_ready;
  assign w_close   = w_accept & ((r_cnt == c_last_lane) | din_last);
  assign din_ready = r_din_ready;
  assign blk_valid = r_blk_valid;
  assign blk_last  = r_blk_last;

  for (genvar gi = 0; gi < RATE_LANES; gi++) begin : g_lane
    assign blk_data[gi*N +: N] = r_buf[gi];
`ifdef KECCAK_PAD_EN
    // In FULL the mask is the pad-only block, loaded when that block is pending.
    keccak_pad_lane #(
      .RATE_LANES (RATE_LANES),
      .N          (N)
    ) u_pad_lane (
      .i_lane_idx   (5'(gi)),
      .i_last_idx   (r_cnt),
      .i_pad_active (w_accept & din_last),
      .i_pad_blk    (r_state == ST_FULL),
      .o_mask       (w_mask[gi])
    );
`else
    assign w_mask[gi] = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_FILL;
      r_cnt         <= 5'd0;
      r_din_ready   <= 1'b1;
      r_blk_valid   <= 1'b0;
      r_blk_last    <= 1'b0;
      r_pad_pending <= 1'b0;
      for (int i = 0; i < RATE_LANES; i++) r_buf[i] <= '0;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (w_accept) begin
            for (int i = 0; i < RATE_LANES; i++) begin
              if (5'(i) == r_cnt) r_buf[i] <= din | w_mask[i];
              else                r_buf[i] <= r_buf[i] | w_mask[i];
            end
            if (w_close) begin
              r_state       <= ST_FULL;
              r_din_ready   <= 1'b0;
              r_blk_valid   <= 1'b1;
              // A message ending on the final lane defers its last flag to the pad block.
              r_blk_last    <= din_last & ~(c_pad_en & (r_cnt == c_last_lane));
              r_pad_pending <= c_pad_en & din_last & (r_cnt == c_last_lane);
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
        end
        ST_FULL: begin
          if (blk_ready) begin
            r_cnt <= 5'd0;
            if (r_pad_pending) begin
              r_state       <= ST_PADBLK;
              r_blk_last    <= 1'b1;
              r_pad_pending <= 1'b0;
              for (int i = 0; i < RATE_LANES; i++) r_buf[i] <= w_mask[i];
            end else begin
              r_state     <= ST_FILL;
              r_din_ready <= 1'b1;
              r_blk_valid <= 1'b0;
              r_blk_last  <= 1'b0;
              for (int i = 0; i < RATE_LANES; i++) r_buf[i] <= '0;
            end
          end
        end
        ST_PADBLK: begin
          if (blk_ready) begin
            r_state     <= ST_FILL;
            r_din_ready <= 1'b1;
            r_blk_valid <= 1'b0;
            r_blk_last  <= 1'b0;
            for (int i = 0; i < RATE_LANES; i++) r_buf[i] <= '0;
          end
        end
        default: begin
          r_state     <= ST_FILL;
          r_din_ready <= 1'b1;
          r_blk_valid <= 1'b0;
          r_blk_last  <= 1'b0;
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_keccak_in_buffer.sv
// tb_keccak_in_buffer: directed self-checking bench for keccak_in_buffer. Rev 1.0
`default_nettype none
module tb_keccak_in_buffer;
  localparam int RL = 17;
  localparam int NW = 64;
  localparam logic [63:0] PAD_HI = 64'h8000_0000_0000_0000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NW-1:0]    din;
  logic             din_valid;
  logic             din_last;
  logic             din_ready;
  logic [RL*NW-1:0] blk_data;
  logic             blk_valid;
  logic             blk_last;
  logic             blk_ready;

  int n_checks = 0;
  int n_errors = 0;
  logic [NW-1:0] exp_lanes [RL];

  always #5 clk = ~clk;

  keccak_in_buffer #(.RATE_LANES(RL), .N(NW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_last  (din_last),
    .din_ready (din_ready),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_last  (blk_last),
    .blk_ready (blk_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] lane(input int i);
    return blk_data[i*NW +: NW];
  endfunction

  task automatic clear_exp();
    for (int i = 0; i < RL; i++) exp_lanes[i] = '0;
  endtask

  task automatic send_lanes(input logic [63:0] base, input int count, input bit last);
    for (int k = 0; k < count; k++) begin
      @(negedge clk);
      din       = base + 64'(k);
      din_valid = 1'b1;
      din_last  = last && (k == count - 1);
    end
    @(negedge clk);
    din_valid = 1'b0;
    din_last  = 1'b0;
  endtask

  task automatic check_block(input string name, input bit exp_last);
    check({name, "_valid"}, 64'(blk_valid), 64'd1);
    check({name, "_last"}, 64'(blk_last), 64'(exp_last));
    check({name, "_din_ready"}, 64'(din_ready), 64'd0);
    for (int i = 0; i < RL; i++)
      check($sformatf("%s_lane%0d", name, i), lane(i), exp_lanes[i]);
  endtask

  task automatic drain(input string name, input bit exp_valid_after);
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
    check({name, "_drain_valid"}, 64'(blk_valid), 64'(exp_valid_after));
    check({name, "_drain_ready"}, 64'(din_ready), 64'(!exp_valid_after));
  endtask

  task automatic check_idle(input string name);
    check({name, "_din_ready"}, 64'(din_ready), 64'd1);
    check({name, "_blk_valid"}, 64'(blk_valid), 64'd0);
    check({name, "_blk_last"}, 64'(blk_last), 64'd0);
    check({name, "_data_zero"}, 64'(|blk_data), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; din = '0; din_valid = 1'b0; din_last = 1'b0; blk_ready = 1'b0;
    @(negedge clk);
    check_idle("rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("rst_release");

    // din_last without din_valid, and blk_ready with no block, are ignored.
    din_last = 1'b1; blk_ready = 1'b1;
    @(negedge clk);
    din_last = 1'b0; blk_ready = 1'b0;
    @(negedge clk);
    check_idle("stray_ctrl");

    // A: 17 lanes 0..16, last on lane 16.
    send_lanes(64'd0, 17, 1'b1);
    clear_exp();
    for (int i = 0; i < RL; i++) exp_lanes[i] = 64'(i);
`ifdef KECCAK_PAD_EN
    check_block("A", 1'b0);
    drain("A", 1'b1);
    clear_exp();
    exp_lanes[0]  = 64'h1;
    exp_lanes[16] = PAD_HI;
    check_block("A_pad", 1'b1);
    drain("A_pad", 1'b0);
`else
    check_block("A", 1'b1);
    drain("A", 1'b0);
`endif

    // B: last on lane 3.
    send_lanes(64'hA0, 4, 1'b1);
    clear_exp();
    for (int i = 0; i < 4; i++) exp_lanes[i] = 64'hA0 + 64'(i);
`ifdef KECCAK_PAD_EN
    exp_lanes[4]  = 64'h1;
    exp_lanes[16] = PAD_HI;
`endif
    check_block("B", 1'b1);
    drain("B", 1'b0);

    // C: last on lane 15.
    send_lanes(64'h200, 16, 1'b1);
    clear_exp();
    for (int i = 0; i < 16; i++) exp_lanes[i] = 64'h200 + 64'(i);
`ifdef KECCAK_PAD_EN
    exp_lanes[16] = PAD_HI | 64'h1;
`endif
    check_block("C", 1'b1);
    drain("C", 1'b0);

    // D: full block without last, then back-pressure with changing din.
    send_lanes(64'h300, 17, 1'b0);
    clear_exp();
    for (int i = 0; i < RL; i++) exp_lanes[i] = 64'h300 + 64'(i);
    check_block("D", 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      din       = 64'hDEAD_0000 + 64'(c);
      din_valid = 1'b1;
      check($sformatf("D_hold%0d_ready", c), 64'(din_ready), 64'd0);
      check($sformatf("D_hold%0d_lane0", c), lane(0), 64'h300);
      check($sformatf("D_hold%0d_lane16", c), lane(16), 64'h310);
    end
    @(negedge clk);
    din_valid = 1'b0;
    check_block("D_held", 1'b0);
    drain("D", 1'b0);

    send_lanes(64'h400, 2, 1'b1);
    clear_exp();
    exp_lanes[0] = 64'h400;
    exp_lanes[1] = 64'h401;
`ifdef KECCAK_PAD_EN
    exp_lanes[2]  = 64'h1;
    exp_lanes[16] = PAD_HI;
`endif
    check_block("D_next", 1'b1);
    drain("D_next", 1'b0);

    // R: reset after a partial fill discards it.
    send_lanes(64'h500, 5, 1'b0);
    rst_n = 1'b0;
    #1;
    check_idle("R_in_rst");
    @(negedge clk);
    check_idle("R_in_rst2");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("R_after");
    send_lanes(64'h100, 17, 1'b0);
    clear_exp();
    for (int i = 0; i < RL; i++) exp_lanes[i] = 64'h100 + 64'(i);
    check_block("R", 1'b0);
    drain("R", 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
